// File: rtl/rv_regfile_pkg.sv
// Shared types and helpers for the multi-port integer register file.
// Parity support is compiled in with RV_REGFILE_PARITY_EN.
package rv_regfile_pkg;

    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } regfile_state_t;

    // Callers size-cast narrower words to 64 bits; zero extension leaves parity unchanged.
    function automatic logic even_parity(input logic [63:0] d);
        return ^d;
    endfunction

    function automatic logic addr_valid(input reg_addr_t a, input int nregs);
        return (a != '0) && (int'(a) < nregs);
    endfunction

endpackage

// File: rtl/rv_regfile_rdport.sv
// One read port: address decode, write bypass, output register and optional parity check.
// RV_REGFILE_PARITY_EN adds the sticky o_parity_err output.
module rv_regfile_rdport
    import rv_regfile_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NUM_WR = 1,
    parameter int MW     = XLEN
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_run,
    input  reg_addr_t                  i_rs,
    input  logic                       i_rd_en,
    input  logic [MW-1:0]              i_rd_word,
    input  logic [NUM_WR-1:0]          i_wr_ok,
    input  logic [NUM_WR*REG_ADDR_W-1:0] i_wr_addr,
    input  logic [NUM_WR*MW-1:0]       i_wr_word,
    output logic [XLEN-1:0]            o_data,
    output logic                       o_wr_hit
`ifdef RV_REGFILE_PARITY_EN
    ,
    output logic                       o_parity_err
`endif
);

    logic [MW-1:0]   sel_word;
    logic [XLEN-1:0] data_reg;

    // Later write ports override earlier ones so the highest-index writer wins.
    always_comb begin
        sel_word = addr_valid(i_rs, NREGS) ? i_rd_word : '0;
        o_wr_hit = 1'b0;
        for (int w = 0; w < NUM_WR; w++) begin
            if (i_wr_ok[w] && (i_wr_addr[w*REG_ADDR_W +: REG_ADDR_W] == i_rs)) begin
                sel_word = i_wr_word[w*MW +: MW];
                o_wr_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            data_reg <= '0;
        end else if (i_run && i_rd_en) begin
            data_reg <= sel_word[XLEN-1:0];
        end
    end

    assign o_data = data_reg;

`ifdef RV_REGFILE_PARITY_EN
    logic parity_err_reg;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            parity_err_reg <= 1'b0;
        end else if (i_run && i_rd_en &&
                     (sel_word[XLEN] != even_parity(64'(sel_word[XLEN-1:0])))) begin
            parity_err_reg <= 1'b1;
        end
    end

    assign o_parity_err = parity_err_reg;
`endif

endmodule

// File: rtl/rv_regfile_mp.sv
// Multi-port RISC-V integer register file with clear sequencer, bypass and busy scoreboard.
// Define RV_REGFILE_PARITY_EN to store a parity bit per register and expose o_parity_err.
module rv_regfile_mp
    import rv_regfile_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic [NUM_RD*REG_ADDR_W-1:0] i_rs,
    input  logic [NUM_RD-1:0]            i_rd_en,
    output logic [NUM_RD*XLEN-1:0]       o_data,
    output logic [NUM_RD-1:0]            o_rs_busy,
    input  logic [NUM_WR-1:0]            i_wr_en,
    input  logic [NUM_WR*REG_ADDR_W-1:0] i_wr_addr,
    input  logic [NUM_WR*XLEN-1:0]       i_wr_data,
    input  logic                         i_busy_set,
    input  reg_addr_t                    i_busy_addr,
    output logic                         o_ready
`ifdef RV_REGFILE_PARITY_EN
    ,
    output logic                         o_parity_err
`endif
);

    localparam int AW = $clog2(NREGS);
`ifdef RV_REGFILE_PARITY_EN
    localparam int MW = XLEN + 1;
`else
    localparam int MW = XLEN;
`endif

    regfile_state_t state_reg, state_next;
    logic [AW-1:0]  clr_cnt_reg, clr_cnt_next;
    logic [NREGS-1:0] busy_reg, busy_next;
    logic [MW-1:0]  mem_reg [NREGS];
    logic           run;
    logic [NUM_WR-1:0]    wr_ok;
    logic [NUM_WR*MW-1:0] wr_word;
    logic [NUM_RD-1:0]    rd_hit;
    logic [NUM_RD-1:0]    port_err;

    assign run     = (state_reg == RF_RUN);
    assign o_ready = run;

    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        if (state_reg == RF_CLEAR) begin
            clr_cnt_next = clr_cnt_reg + 1'b1;
            if (clr_cnt_reg == AW'(NREGS - 1)) begin
                state_next = RF_RUN;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_reg   <= RF_CLEAR;
            clr_cnt_reg <= AW'(1);
            busy_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
            busy_reg    <= busy_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WR; gi++) begin : g_wr
            assign wr_ok[gi] = run & i_wr_en[gi] &
                               addr_valid(i_wr_addr[gi*REG_ADDR_W +: REG_ADDR_W], NREGS);
`ifdef RV_REGFILE_PARITY_EN
            assign wr_word[gi*MW +: MW] = {even_parity(64'(i_wr_data[gi*XLEN +: XLEN])),
                                           i_wr_data[gi*XLEN +: XLEN]};
`else
            assign wr_word[gi*MW +: MW] = i_wr_data[gi*XLEN +: XLEN];
`endif
        end
    endgenerate

    // No reset on the array: the sequencer zeroes x1..xN-1 after every reset.
    always_ff @(posedge i_clk) begin
        if (state_reg == RF_CLEAR) begin
            mem_reg[clr_cnt_reg] <= '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_ok[w]) begin
                    mem_reg[i_wr_addr[w*REG_ADDR_W +: AW]] <= wr_word[w*MW +: MW];
                end
            end
        end
    end

    // Set is applied after the clears so a new producer supersedes a same-cycle writeback.
    always_comb begin
        busy_next = busy_reg;
        if (run) begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_ok[w]) begin
                    busy_next[i_wr_addr[w*REG_ADDR_W +: AW]] = 1'b0;
                end
            end
            if (i_busy_set && addr_valid(i_busy_addr, NREGS)) begin
                busy_next[i_busy_addr[AW-1:0]] = 1'b1;
            end
        end
        busy_next[0] = 1'b0;
    end

    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            rv_regfile_rdport #(
                .XLEN   (XLEN),
                .NREGS  (NREGS),
                .NUM_WR (NUM_WR),
                .MW     (MW)
            ) u_rdport (
                .i_clk        (i_clk),
                .i_reset_n    (i_reset_n),
                .i_run        (run),
                .i_rs         (i_rs[gi*REG_ADDR_W +: REG_ADDR_W]),
                .i_rd_en      (i_rd_en[gi]),
                .i_rd_word    (mem_reg[i_rs[gi*REG_ADDR_W +: AW]]),
                .i_wr_ok      (wr_ok),
                .i_wr_addr    (i_wr_addr),
                .i_wr_word    (wr_word),
                .o_data       (o_data[gi*XLEN +: XLEN]),
                .o_wr_hit     (rd_hit[gi])
`ifdef RV_REGFILE_PARITY_EN
                ,
                .o_parity_err (port_err[gi])
`endif
            );
`ifndef RV_REGFILE_PARITY_EN
            assign port_err[gi] = 1'b0;
`endif
            assign o_rs_busy[gi] = run &
                                   addr_valid(i_rs[gi*REG_ADDR_W +: REG_ADDR_W], NREGS) &
                                   busy_reg[i_rs[gi*REG_ADDR_W +: AW]] & ~rd_hit[gi];
        end
    endgenerate

`ifdef RV_REGFILE_PARITY_EN
    assign o_parity_err = |port_err;
`else
    logic unused_err;
    assign unused_err = |port_err;
`endif

endmodule

// File: doc/rv_regfile_mp.md
Name: rv_regfile_mp

Overview:
- Parametrised multi-port integer register file for the RISC-V core; successor to the single-issue 2R1W file.
- Configurable XLEN, register count (RV32I 32 / RV32E 16), read-port count and write-port count.
- Adds a power-on clear sequencer, write-to-read bypass and a per-register busy scoreboard for hazard detection.
- Sits between decode (read/busy query), issue (busy set) and writeback (write, busy clear).

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, architectural register count; legal values 16 or 32; x0 always included.
- NUM_RD, 2, number of read ports (1..4).
- NUM_WR, 1, number of write ports (1..2).

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  reset; synchronous, active-low; clock i_clk.
- i_rs  in  NUM_RD*5  read addresses, port p at bits [p*5+:5].
- i_rd_en  in  NUM_RD  per-port read capture enable.
- o_data  out  NUM_RD*XLEN  registered read data, port p at [p*XLEN+:XLEN].
- o_rs_busy  out  NUM_RD  combinational: i_rs[p] has a pending producer.
- i_wr_en  in  NUM_WR  per-port write enable.
- i_wr_addr  in  NUM_WR*5  write addresses.
- i_wr_data  in  NUM_WR*XLEN  write data.
- i_busy_set  in  1  mark i_busy_addr pending (issue of a writing instruction).
- i_busy_addr  in  5  register to mark busy.
- o_ready  out  1  high once the clear sequence is done.

Behaviour:
- Reset (i_reset_n low at a clock edge):
  - FSM goes to CLEAR with clr_cnt=1.
  - o_ready=0, all o_data=0, all busy bits=0.
  - Reset asserted mid-CLEAR or mid-RUN restarts CLEAR from 1.
- CLEAR state:
  - Each cycle writes 0 to reg[clr_cnt], then increments clr_cnt.
  - After writing index NREGS-1, goes to RUN; o_ready=1 from the next cycle.
  - Total duration is NREGS-1 cycles after reset release.
  - In CLEAR, external writes and i_busy_set are ignored, o_data holds 0 and o_rs_busy=0.
- RUN state, read path:
  - Latency 1. When i_rd_en[p]=1 at an edge, o_data[p] captures the register's value; when i_rd_en[p]=0, o_data[p] holds.
  - i_rs[p]==0 or i_rs[p]>=NREGS returns 0.
- Bypass:
  - If a same-cycle write targets i_rs[p] (nonzero, in range), o_data[p] captures the write data, not the old contents.
- Writes:
  - Take effect at the edge.
  - Addr 0 or >=NREGS is ignored.
  - Two write ports to the same address in the same cycle: the higher-index port wins, for both storage and bypass.
- Scoreboard (one busy bit per register 1..NREGS-1):
  - i_busy_set sets busy[i_busy_addr].
  - Any accepted write clears busy[addr].
  - Set and clear on the same address in the same cycle: set wins (a new producer supersedes the old one).
  - Addr 0 is never busy.
  - o_rs_busy[p] = busy[i_rs[p]] & ~(same-cycle write to i_rs[p]), so a writeback in the current cycle resolves the hazard without a stall bubble.
- Storage:
  - No reset on the array itself; clearing is done by the sequencer.
  - Array is inferable as distributed RAM.

Optional Feature:
- Macro RV_REGFILE_PARITY_EN.
- Defined:
  - Each register stores an extra even-parity bit computed on write (CLEAR writes parity 0).
  - Each read port recomputes parity on the captured value.
  - Adds sticky output o_parity_err (1 bit, reset 0), set when any port's captured data mismatches its stored parity.
  - o_parity_err is cleared only by reset.
- Not defined: no parity storage, no o_parity_err port.

Decomposition:
- Package rv_regfile_pkg:
  - REG_ADDR_W=5.
  - typedef reg_addr_t (logic[4:0]).
  - FSM enum regfile_state_t {RF_CLEAR, RF_RUN}.
  - Function even_parity.
- Sub-module rv_regfile_rdport: one instance per read port. It contains address decode, bypass mux across write ports, the output register and the optional parity check.

Test Plan:
- Reset release with NREGS=32 → o_ready low for 31 cycles then high; reading x1..x31 returns 0; o_rs_busy all 0.
- RUN: write x5=0xDEADBEEF, next cycle i_rs[0]=5 with i_rd_en → o_data[0]=0xDEADBEEF one cycle later; with i_rd_en=0 the value holds; a write to x0 followed by a read of x0 → 0.
- Same-cycle write x7=0x12345678 and read x7 (old value 0x1) → o_data=0x12345678. With NUM_WR=2, both ports write x7 (0xA, 0xB) → 0xB stored and returned.
- Scoreboard:
  - i_busy_set x3 → o_rs_busy=1 for rs=3 until writeback.
  - The writeback cycle shows o_rs_busy=0.
  - Simultaneous set and write of x3 → busy stays 1.
- NREGS=16: write x20 ignored, read x20 → 0; clear takes 15 cycles. Reset asserted at clear cycle 8 → sequence restarts and o_ready is delayed accordingly.
- RV_REGFILE_PARITY_EN: force a flipped bit into a storage entry via the bench, then read it → o_parity_err=1 and sticky until reset.
